// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller:
// request length encodings, FSM state encoding and data/address widths.
package mem_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int W_PORT = 1;

    // Length field is byte count minus one.
    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_3 = 2'd2;
    localparam logic [1:0] LEN_W = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Keeps only the bytes a read of this length actually fetched.
    function automatic logic [DATA_W-1:0] len_mask(input logic [1:0] len);
        case (len)
            LEN_B:   len_mask = 32'h0000_00FF;
            LEN_H:   len_mask = 32'h0000_FFFF;
            LEN_3:   len_mask = 32'h00FF_FFFF;
            LEN_W:   len_mask = 32'hFFFF_FFFF;
            default: len_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the core request ports and mem_ctrl.
// master = core side (drives requests), slave = controller side.
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int R_PORT = 2
);

    logic [R_PORT-1:0]        req_re;
    logic [R_PORT*ADDR_W-1:0] req_raddr;
    logic [R_PORT*2-1:0]      req_rlen;
    logic                     req_we;
    logic [ADDR_W-1:0]        req_waddr;
    logic [1:0]               req_wlen;
    logic [DATA_W-1:0]        req_wdata;

    logic [R_PORT*DATA_W-1:0] rsp_rdata;
    logic [R_PORT-1:0]        rsp_rdone;
    logic                     rsp_wdone;

    modport master (
        output req_re, req_raddr, req_rlen, req_we, req_waddr, req_wlen, req_wdata,
        input  rsp_rdata, rsp_rdone, rsp_wdone
    );

    modport slave (
        input  req_re, req_raddr, req_rlen, req_we, req_waddr, req_wlen, req_wdata,
        output rsp_rdata, rsp_rdone, rsp_wdone
    );

endinterface

// File: rtl/mem_arbiter.sv
// Request arbiter: write always wins; reads are round-robin when
// MEM_RR_ARB_EN is defined, otherwise fixed highest-index-first.
module mem_arbiter #(
    parameter int R_PORT = 2
) (
`ifdef MEM_RR_ARB_EN
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
`endif
    input  logic [R_PORT-1:0] re,
    input  logic              we,
    output logic [R_PORT-1:0] gnt,
    output logic              is_wr,
    output logic              any
);

    assign is_wr = we;
    assign any   = we | (|re);

`ifdef MEM_RR_ARB_EN
    localparam int PTR_W = (R_PORT > 1) ? $clog2(R_PORT) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] cand [R_PORT];

    // cand[i] is the port with the i-th highest priority this cycle.
    generate
        for (genvar gi = 0; gi < R_PORT; gi++) begin : g_cand
            assign cand[gi] = PTR_W'((int'(ptr_reg) + gi) % R_PORT);
        end
    endgenerate

    // Scan lowest priority first so the last hit is the winner.
    always_comb begin
        gnt      = '0;
        ptr_next = ptr_reg;
        if (!we) begin
            for (int i = R_PORT - 1; i >= 0; i--) begin
                if (re[cand[i]]) begin
                    gnt           = '0;
                    gnt[cand[i]]  = 1'b1;
                    ptr_next      = PTR_W'((int'(cand[i]) + 1) % R_PORT);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (adv) begin
            ptr_reg <= ptr_next;
        end
    end
`else
    always_comb begin
        gnt = '0;
        if (!we) begin
            for (int i = 0; i < R_PORT; i++) begin
                if (re[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Serialises granted read/write requests onto a byte-wide synchronous RAM
// (little-endian) and pulses per-port done. Read arbitration style is
// selected by MEM_RR_ARB_EN (round-robin when defined, fixed otherwise).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int R_PORT = 2,
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl_if.slave         bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    state_t                   state_reg;
    state_t                   state_next;
    logic [RAM_AW-1:0]        addr_reg;
    logic [1:0]               len_reg;
    logic [DATA_W-1:0]        wdata_reg;
    logic [R_PORT-1:0]        gnt_reg;
    logic                     is_wr_reg;
    logic [2:0]               cnt_reg;
    logic [DATA_W-1:0]        asm_reg;
    logic [DATA_W-1:0]        asm_next;
    logic [R_PORT*DATA_W-1:0] rdata_reg;

    logic [R_PORT-1:0]        arb_gnt;
    logic                     arb_is_wr;
    logic                     arb_any;
    logic [RAM_AW-1:0]        sel_addr;
    logic [1:0]               sel_len;
    logic [2:0]               last_idx;
    logic                     rd_drain;
    logic [1:0]               cap_idx;

    logic [ADDR_W-1:0]        raddr_arr [R_PORT];
    logic [1:0]               rlen_arr  [R_PORT];
    logic                     unused_waddr_hi;

    generate
        for (genvar gi = 0; gi < R_PORT; gi++) begin : g_port
            logic unused_raddr_hi;
            assign raddr_arr[gi]       = bus.req_raddr[gi*ADDR_W +: ADDR_W];
            assign rlen_arr[gi]        = bus.req_rlen[gi*2 +: 2];
            assign unused_raddr_hi     = ^raddr_arr[gi][ADDR_W-1:RAM_AW];
            assign bus.rsp_rdone[gi]   = (state_reg == ST_DONE) && !is_wr_reg && gnt_reg[gi];
        end
    endgenerate

    assign unused_waddr_hi = ^bus.req_waddr[ADDR_W-1:RAM_AW];
    assign bus.rsp_wdone   = (state_reg == ST_DONE) && is_wr_reg;
    assign bus.rsp_rdata   = rdata_reg;

`ifdef MEM_RR_ARB_EN
    logic arb_adv;
    assign arb_adv = (state_reg == ST_IDLE) && arb_any && !arb_is_wr;
`endif

    mem_arbiter #(
        .R_PORT (R_PORT)
    ) u_arb (
`ifdef MEM_RR_ARB_EN
        .clk    (clk),
        .rst    (rst),
        .adv    (arb_adv),
`endif
        .re     (bus.req_re),
        .we     (bus.req_we),
        .gnt    (arb_gnt),
        .is_wr  (arb_is_wr),
        .any    (arb_any)
    );

    // Address/length of whichever request the arbiter picked this cycle.
    always_comb begin
        sel_addr = bus.req_waddr[RAM_AW-1:0];
        sel_len  = bus.req_wlen;
        if (!arb_is_wr) begin
            for (int p = 0; p < R_PORT; p++) begin
                if (arb_gnt[p]) begin
                    sel_addr = raddr_arr[p][RAM_AW-1:0];
                    sel_len  = rlen_arr[p];
                end
            end
        end
    end

    assign last_idx = {1'b0, len_reg};
    // Reads spend one extra cycle after the final issue to catch its byte.
    assign rd_drain = (cnt_reg == last_idx + 3'd1);
    // The byte arriving now was issued one cycle earlier.
    assign cap_idx  = cnt_reg[1:0] - 2'd1;

    always_comb begin
        asm_next                          = asm_reg;
        asm_next[{cap_idx, 3'b000} +: 8]  = ram_rdata;
    end

    always_comb begin
        state_next = state_reg;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_we     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arb_any) begin
                    state_next = arb_is_wr ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                ram_addr  = addr_reg + RAM_AW'(cnt_reg);
                ram_wdata = wdata_reg[{cnt_reg[1:0], 3'b000} +: 8];
                ram_we    = 1'b1;
                if (cnt_reg == last_idx) begin
                    state_next = ST_DONE;
                end
            end
            ST_RD: begin
                ram_addr = addr_reg + RAM_AW'(cnt_reg);
                if (rd_drain) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            len_reg   <= '0;
            wdata_reg <= '0;
            gnt_reg   <= '0;
            is_wr_reg <= 1'b0;
            cnt_reg   <= '0;
            asm_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    asm_reg <= '0;
                    if (arb_any) begin
                        addr_reg  <= sel_addr;
                        len_reg   <= sel_len;
                        wdata_reg <= bus.req_wdata;
                        gnt_reg   <= arb_gnt;
                        is_wr_reg <= arb_is_wr;
                    end
                end
                ST_WR: begin
                    cnt_reg <= cnt_reg + 3'd1;
                end
                ST_RD: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg != 3'd0) begin
                        asm_reg <= asm_next;
                    end
                    // Publish the word so it is valid alongside the done pulse.
                    if (rd_drain) begin
                        for (int p = 0; p < R_PORT; p++) begin
                            if (gnt_reg[p]) begin
                                rdata_reg[p*DATA_W +: DATA_W] <= asm_next & len_mask(len_reg);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a behavioural RAM, a shadow-memory model that
// predicts done cycles and read data, and a per-cycle compare process.
module tb_mem_ctrl;

    localparam int R_PORT   = 2;
    localparam int RAM_AW   = 17;
    localparam int RAM_SIZE = 1 << RAM_AW;
    localparam int AMASK    = RAM_SIZE - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata = 8'h00;

    mem_ctrl_if #(.R_PORT(R_PORT)) bus ();

    mem_ctrl #(.R_PORT(R_PORT), .RAM_AW(RAM_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Byte-wide synchronous RAM with registered read.
    logic [7:0] ram_mem [0:RAM_SIZE-1] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int   cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Expected-event table: filled by the stimulus, consumed by the compare.
    int          exp_n = 0;
    int          exp_cyc  [64];
    bit          exp_wr   [64];
    int          exp_port [64];
    logic [31:0] exp_data [64];

    int main_chk = 0, main_err = 0;
    int cmp_chk = 0,  cmp_err = 0;

    // ---------------- compare process ----------------
    logic [31:0] last_rdata [R_PORT] = '{default: 32'h0};
    always @(negedge clk) begin
        logic [R_PORT-1:0] er;
        logic              ew;
        er = '0;
        ew = 1'b0;
        if (rst_seen) begin
            for (int p = 0; p < R_PORT; p++) last_rdata[p] = 32'h0;
        end
        for (int k = 0; k < exp_n; k++) begin
            if (exp_cyc[k] == cyc) begin
                if (exp_wr[k]) ew = 1'b1;
                else begin
                    er[exp_port[k]]       = 1'b1;
                    last_rdata[exp_port[k]] = exp_data[k];
                end
            end
        end
        cmp_chk++;
        if (bus.rsp_rdone !== er) begin
            cmp_err++;
            $display("FAIL rsp_rdone: got %b expected %b (cycle %0d)", bus.rsp_rdone, er, cyc);
        end
        cmp_chk++;
        if (bus.rsp_wdone !== ew) begin
            cmp_err++;
            $display("FAIL rsp_wdone: got %b expected %b (cycle %0d)", bus.rsp_wdone, ew, cyc);
        end
        for (int p = 0; p < R_PORT; p++) begin
            cmp_chk++;
            if (bus.rsp_rdata[p*32 +: 32] !== last_rdata[p]) begin
                cmp_err++;
                $display("FAIL rsp_rdata%0d: got %h expected %h (cycle %0d)",
                         p, bus.rsp_rdata[p*32 +: 32], last_rdata[p], cyc);
            end
        end
        if (bus.rsp_wdone) $display("txn cycle=%0d write done", cyc);
        for (int p = 0; p < R_PORT; p++)
            if (bus.rsp_rdone[p])
                $display("txn cycle=%0d read done port=%0d data=%h", cyc, p, bus.rsp_rdata[p*32 +: 32]);
    end

    // ---------------- model + stimulus ----------------
    logic [7:0] shadow [0:RAM_SIZE-1];
    int         model_ptr = 0;
    int         last_wr_cyc = -1;
    int         last_rd_cyc [R_PORT] = '{default: -1};
    bit         pend [R_PORT] = '{default: 1'b0};
    bit         auto_on = 1'b0;
    int         auto_dones = 0;
    int         order [8];
    int         ord_n = 0;

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        main_chk++;
        if (act !== exp) begin
            main_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr, input int len);
        logic [31:0] d;
        d = 32'h0;
        for (int i = 0; i <= len; i++) d[8*i +: 8] = shadow[(addr + i) & AMASK];
        return d;
    endfunction

    task automatic push(input int c, input bit wr, input int p, input logic [31:0] d);
        exp_cyc[exp_n]  = c;
        exp_wr[exp_n]   = wr;
        exp_port[exp_n] = p;
        exp_data[exp_n] = d;
        exp_n++;
    endtask

    // One cycle: reraise pending ports, then retire any done requests.
    task automatic tick();
        @(negedge clk);
        for (int p = 0; p < R_PORT; p++) begin
            if (pend[p]) begin
                bus.req_re[p] = 1'b1;
                pend[p] = 1'b0;
            end
        end
        for (int p = 0; p < R_PORT; p++) begin
            if (bus.rsp_rdone[p]) begin
                bus.req_re[p] = 1'b0;
                last_rd_cyc[p] = cyc;
                if (auto_on) begin
                    order[ord_n] = p;
                    ord_n++;
                    if (auto_dones < 3) pend[p] = 1'b1;
                    auto_dones++;
                end
            end
        end
        if (bus.rsp_wdone) begin
            bus.req_we = 1'b0;
            last_wr_cyc = cyc;
        end
    endtask

    task automatic wait_until(input int c);
        int lim;
        lim = cyc + 2000;
        while (cyc < c && cyc < lim) tick();
        if (cyc < c) mchk("wait_budget", cyc, c);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [31:0] data, output int t);
        bus.req_waddr = addr;
        bus.req_wlen  = 2'(len);
        bus.req_wdata = data;
        bus.req_we    = 1'b1;
        t = cyc;
        push(t + len + 2, 1'b1, 0, 32'h0);
        for (int i = 0; i <= len; i++) shadow[(addr + i) & AMASK] = data[8*i +: 8];
    endtask

    task automatic push_read(input int p, input logic [31:0] addr, input int len, input int gcyc);
        push(gcyc + len + 3, 1'b0, p, model_read(addr, len));
        model_ptr = (p + 1) % R_PORT;
    endtask

    task automatic do_read(input int p, input logic [31:0] addr, input int len, input int gcyc);
        bus.req_raddr[32*p +: 32] = addr;
        bus.req_rlen[2*p +: 2]    = 2'(len);
        bus.req_re[p]             = 1'b1;
        push_read(p, addr, len, gcyc);
    endtask

    initial begin
        int t;
        bit held [R_PORT];
        int pick;
        int exp_ord [5];

        bus.req_re = '0; bus.req_raddr = '0; bus.req_rlen = '0;
        bus.req_we = 1'b0; bus.req_waddr = '0; bus.req_wlen = '0; bus.req_wdata = '0;
        for (int i = 0; i < RAM_SIZE; i++) shadow[i] = 8'h00;

        repeat (3) @(negedge clk);
        mchk("reset_ram_we",    {31'b0, ram_we}, 32'h0);
        mchk("reset_ram_addr",  32'(ram_addr), 32'h0);
        mchk("reset_rdone",     32'(bus.rsp_rdone), 32'h0);
        mchk("reset_wdone",     {31'b0, bus.rsp_wdone}, 32'h0);
        mchk("reset_rdata",     bus.rsp_rdata[63:32] | bus.rsp_rdata[31:0], 32'h0);
        rst = 1'b0;

        // Word write then word read on port 1.
        tick(); do_write(32'h100, 3, 32'hDEADBEEF, t); wait_until(t + 8);
        mchk("wr_latency", last_wr_cyc - t, 5);
        mchk("ram_100", {24'h0, ram_mem[17'h100]}, 32'hEF);
        mchk("ram_101", {24'h0, ram_mem[17'h101]}, 32'hBE);
        mchk("ram_102", {24'h0, ram_mem[17'h102]}, 32'hAD);
        mchk("ram_103", {24'h0, ram_mem[17'h103]}, 32'hDE);
        tick(); t = cyc; do_read(1, 32'h100, 3, t); wait_until(t + 9);
        mchk("rd_latency", last_rd_cyc[1] - t, 6);
        mchk("rd_word", bus.rsp_rdata[63:32], 32'hDEADBEEF);

        // Byte and half reads on port 0.
        tick(); t = cyc; do_read(0, 32'h101, 0, t); wait_until(t + 5);
        mchk("rd_byte_latency", last_rd_cyc[0] - t, 3);
        mchk("rd_byte", bus.rsp_rdata[31:0], 32'h000000BE);
        tick(); t = cyc; do_read(0, 32'h102, 1, t); wait_until(t + 6);
        mchk("rd_half", bus.rsp_rdata[31:0], 32'h0000DEAD);

        // Simultaneous write and read to the same address.
        tick(); do_write(32'h20, 3, 32'h11223344, t); do_read(1, 32'h20, 3, t + 6);
        wait_until(t + 15);
        mchk("wr_first", last_wr_cyc - t, 5);
        mchk("rd_after_wr_latency", last_rd_cyc[1] - t, 12);
        mchk("rd_after_wr", bus.rsp_rdata[63:32], 32'h11223344);

        // Both read ports held continuously.
        tick(); do_write(32'h300, 3, 32'h0A0B0C0D, t); wait_until(t + 7);
        tick(); do_write(32'h304, 3, 32'h01020304, t); wait_until(t + 7);
        tick(); t = cyc;
        bus.req_raddr[31:0]  = 32'h300; bus.req_rlen[1:0] = 2'd3;
        bus.req_raddr[63:32] = 32'h304; bus.req_rlen[3:2] = 2'd3;
        held[0] = 1'b1; held[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
`ifdef MEM_RR_ARB_EN
            pick = held[model_ptr] ? model_ptr : (1 - model_ptr);
`else
            pick = held[1] ? 1 : 0;
`endif
            push_read(pick, (pick == 0) ? 32'h300 : 32'h304, 3, t + 7 * k);
            held[pick] = (k < 3);
        end
        auto_on = 1'b1; auto_dones = 0; ord_n = 0;
        bus.req_re = 2'b11;
        wait_until(t + 7 * 4 + 9);
        auto_on = 1'b0;
`ifdef MEM_RR_ARB_EN
        exp_ord = '{0, 1, 0, 1, 0};
`else
        exp_ord = '{1, 1, 1, 1, 0};
`endif
        mchk("arb_count", ord_n, 5);
        for (int k = 0; k < 5; k++) mchk($sformatf("arb_order%0d", k), order[k], exp_ord[k]);

        // Address wrap at the top of the RAM.
        tick(); do_write(32'h0001FFFE, 3, 32'hAABBCCDD, t); wait_until(t + 7);
        mchk("wrap_1fffe", {24'h0, ram_mem[17'h1FFFE]}, 32'hDD);
        mchk("wrap_1ffff", {24'h0, ram_mem[17'h1FFFF]}, 32'hCC);
        mchk("wrap_00000", {24'h0, ram_mem[17'h00000]}, 32'hBB);
        mchk("wrap_00001", {24'h0, ram_mem[17'h00001]}, 32'hAA);
        tick(); t = cyc; do_read(0, 32'hABC1FFFF, 3, t); wait_until(t + 9);
        mchk("wrap_read", bus.rsp_rdata[31:0], 32'h00AABBCC);

        // Reset during cycle 2 of a word write.
        tick(); t = cyc;
        bus.req_waddr = 32'h400; bus.req_wlen = 2'd3; bus.req_wdata = 32'h55667788; bus.req_we = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        mchk("rst_ram_we", {31'b0, ram_we}, 32'h0);
        mchk("rst_wdone", {31'b0, bus.rsp_wdone}, 32'h0);
        mchk("rst_rdata", bus.rsp_rdata[63:32] | bus.rsp_rdata[31:0], 32'h0);
        rst = 1'b0; bus.req_we = 1'b0;
        model_ptr = 0;
        shadow[17'h400] = 8'h88; shadow[17'h401] = 8'h77;
        mchk("rst_partial", {16'h0, ram_mem[17'h401], ram_mem[17'h400]}, 32'h7788);
        tick(); t = cyc; do_read(1, 32'h400, 3, t); wait_until(t + 10);
        mchk("post_rst_latency", last_rd_cyc[1] - t, 6);
        mchk("post_rst_read", bus.rsp_rdata[63:32], 32'h00007788);

        tick();
        $display("Result: errors=%0d of %0d checks", main_err + cmp_err, main_chk + cmp_chk);
        $finish;
    end

endmodule
